framebuffer_scanout: RTL and testbench

Reads the finished frame buffer and drives a 640x480@60 VGA output. It upscales the BUFFER_WIDTH x BUFFER_HEIGHT buffer by SCALE. It sits at the read end of the double-buffered frame store, opposite the drawing manager. It owns the front/back buffer swap: it answers the drawer's frame_done with draw_ack, and only at the start of vertical blanking.

---
 rtl/types_pkg.sv | 41 ++++
 rtl/framebuffer_scanout_vga_timing.sv | 55 +++++
 rtl/framebuffer_scanout.sv | 148 ++++++++++++++
 tb/tb_framebuffer_scanout.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared VGA 640x480@60 timing constants, the RGB444 pixel type and the
// colour-bar lookup used by framebuffer_scanout and VgaTiming.
// -----------------------------------------------------------------------------
package types_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

    localparam logic [9:0] BAR_WIDTH = 10'd80;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hF00;
            3'd1:    return 12'h0F0;
            3'd2:    return 12'h00F;
            3'd3:    return 12'hFF0;
            3'd4:    return 12'h0FF;
            3'd5:    return 12'hF0F;
            3'd6:    return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/framebuffer_scanout_vga_timing.sv
// -----------------------------------------------------------------------------
// VgaTiming
// Free-running 800x525 pixel/line counters for 640x480@60.
// Ports:
//   clk_i, rstn_i     pixel clock, asynchronous active-low reset
//   h_count_o         pixel within line, 0..799
//   v_count_o         line within frame, 0..524
//   hsync_raw_o       active-low horizontal sync, undelayed
//   vsync_raw_o       active-low vertical sync, undelayed
//   visible_o         inside the 640x480 active area
//   swap_point_o      single cycle per frame at h=0, v=480
// -----------------------------------------------------------------------------
module VgaTiming
    import types_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    output logic [9:0] h_count_o,
    output logic [9:0] v_count_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o,
    output logic       visible_o,
    output logic       swap_point_o
);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_TOTAL - 10'd1) begin
            h_d = '0;
            v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count_o    = h_q;
    assign v_count_o    = v_q;
    assign hsync_raw_o  = !((h_q >= H_VISIBLE + H_FRONT) && (h_q < H_VISIBLE + H_FRONT + H_SYNC));
    assign vsync_raw_o  = !((v_q >= V_VISIBLE + V_FRONT) && (v_q < V_VISIBLE + V_FRONT + V_SYNC));
    assign visible_o    = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    assign swap_point_o = (h_q == '0) && (v_q == V_VISIBLE);

endmodule

// File: rtl/framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout
// Scans the front frame buffer out to 640x480@60 VGA, upscaling by SCALE,
// and performs the front/back swap only at the start of vertical blanking.
// Optional feature macro: SCANOUT_TEST_PATTERN_EN (8 vertical colour bars
// replace read_data; sync, latency and swap handshake unchanged).
// Ports:
//   clk, rstn          pixel clock, asynchronous active-low reset
//   frame_done         drawer finished the back buffer (held until draw_ack)
//   draw_ack           one-cycle pulse after a swap
//   buffer_select      front buffer index; drawer uses ~buffer_select
//   read_en/read_addr  frame buffer read port (registered RAM, 1-cycle)
//   read_data          returned RGB444 pixel
//   vga_hsync/vsync    active-low syncs, aligned with colour
//   vga_r/g/b          4-bit colour, black during blanking
// Pipeline: stage 0 counters/address, stage 1 RAM data, stage 2 outputs.
// -----------------------------------------------------------------------------
module framebuffer_scanout
    import types_pkg::*;
#(
    parameter int BUFFER_WIDTH      = 160,
    parameter int BUFFER_HEIGHT     = 120,
    parameter int BUFFER_DATA_WIDTH = 12,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
    parameter int SCALE             = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         frame_done,
    output logic                         draw_ack,
    output logic                         buffer_select,
    output logic                         read_en,
    output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] read_data,
    output logic                         vga_hsync,
    output logic                         vga_vsync,
    output logic [3:0]                   vga_r,
    output logic [3:0]                   vga_g,
    output logic [3:0]                   vga_b
);

    localparam int unsigned SHIFT = $clog2(SCALE);

    logic [9:0] h_count, v_count;
    logic       hsync_raw, vsync_raw, visible, swap_point;

    VgaTiming u_timing (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .h_count_o    (h_count),
        .v_count_o    (v_count),
        .hsync_raw_o  (hsync_raw),
        .vsync_raw_o  (vsync_raw),
        .visible_o    (visible),
        .swap_point_o (swap_point)
    );

    // Stage 0: address straight from the counters. Gating with rstn keeps the
    // read strobe low while held in reset even though (0,0) is visible.
    assign read_en   = visible && rstn;
    assign read_addr = read_en
        ? BUFFER_ADDR_WIDTH'(32'(v_count >> SHIFT) * 32'(BUFFER_WIDTH) + 32'(h_count >> SHIFT))
        : '0;

    // Swap handshake: only the swap-point cycle can toggle, so the front
    // buffer is stable across the whole visible region.
    logic bsel_q, bsel_d;
    logic ack_q, ack_d;

    always_comb begin
        bsel_d = bsel_q;
        ack_d  = 1'b0;
        if (swap_point && frame_done) begin
            bsel_d = ~bsel_q;
            ack_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bsel_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            bsel_q <= bsel_d;
            ack_q  <= ack_d;
        end
    end

    assign buffer_select = bsel_q;
    assign draw_ack      = ack_q;

    // Stage 1: timing flags travel alongside the RAM access.
    logic    vis_s1_q, hs_s1_q, vs_s1_q;
    rgb444_t src_pix;

`ifdef SCANOUT_TEST_PATTERN_EN
    rgb444_t bar_s1_q;
    logic    unused_read_data;

    assign unused_read_data = ^read_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) bar_s1_q <= '0;
        else       bar_s1_q <= bar_colour(3'(h_count / BAR_WIDTH));
    end

    assign src_pix = bar_s1_q;
`else
    assign src_pix = rgb444_t'(read_data);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vis_s1_q <= 1'b0;
            hs_s1_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
        end else begin
            vis_s1_q <= visible;
            hs_s1_q  <= hsync_raw;
            vs_s1_q  <= vsync_raw;
        end
    end

    // Stage 2: registered outputs, black outside the active area.
    rgb444_t rgb_q, rgb_d;
    logic    hsync_q, vsync_q;

    assign rgb_d = vis_s1_q ? src_pix : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hs_s1_q;
            vsync_q <= vs_s1_q;
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_r     = rgb_q.r;
    assign vga_g     = rgb_q.g;
    assign vga_b     = rgb_q.b;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_scanout
// Self-checking bench for framebuffer_scanout: random RAM contents, a
// cycle-indexed reference model, a per-cycle compare and pinned literals.
// -----------------------------------------------------------------------------
module tb_framebuffer_scanout;

    localparam int BW = 160;
    localparam int BH = 120;
    localparam int AW = 15;
    localparam int N  = BW * BH;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          frame_done = 1'b0;
    logic          draw_ack, buffer_select, read_en;
    logic [AW-1:0] read_addr;
    logic [11:0]   read_data = '0;
    logic          vga_hsync, vga_vsync;
    logic [3:0]    vga_r, vga_g, vga_b;

    framebuffer_scanout #(
        .BUFFER_WIDTH      (BW),
        .BUFFER_HEIGHT     (BH),
        .BUFFER_DATA_WIDTH (12),
        .BUFFER_ADDR_WIDTH (AW),
        .SCALE             (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .frame_done    (frame_done),
        .draw_ack      (draw_ack),
        .buffer_select (buffer_select),
        .read_en       (read_en),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b)
    );

    always #5 clk = ~clk;

    // Double-buffered registered RAM.
    logic [11:0] mem [2][N];

    always @(posedge clk)
        if (read_en) read_data <= mem[buffer_select][read_addr];

    // Reference model, indexed by cycles since reset release.
    int   cyc = 0;
    logic exp_bs = 1'b0;
    logic exp_ack = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acks = 0;

    function automatic logic m_vis(input int c);
        return ((c % 800) < 640) && (((c / 800) % 525) < 480);
    endfunction

    function automatic logic [AW-1:0] m_addr(input int c);
        int h, v;
        h = c % 800;
        v = (c / 800) % 525;
        if (!m_vis(c)) return '0;
        return AW'((v / 4) * BW + (h / 4));
    endfunction

    function automatic logic [11:0] m_pix(input int c);
        logic [11:0] bars [8];
        bars = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF, 12'h000};
        if (!m_vis(c)) return 12'h000;
`ifdef SCANOUT_TEST_PATTERN_EN
        return bars[(c % 800) / 80];
`else
        return mem[exp_bs][m_addr(c)];
`endif
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            cyc     = 0;
            exp_bs  = 1'b0;
            exp_ack = 1'b0;
        end else begin
            if ((cyc % 800) == 0 && ((cyc / 800) % 525) == 480 && frame_done) begin
                exp_bs  = ~exp_bs;
                exp_ack = 1'b1;
            end else begin
                exp_ack = 1'b0;
            end
            cyc++;
        end
    end

    task automatic summary_and_finish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
            if (n_fail >= 100) summary_and_finish();
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [31:0] act, exp;
        logic        hs, vs;
        logic [11:0] col;
        act = {read_en, read_addr, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, buffer_select, draw_ack};
        if (!rstn) begin
            exp = {1'b0, 15'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
        end else begin
            hs  = 1'b1;
            vs  = 1'b1;
            col = 12'h000;
            if (cyc >= 2) begin
                hs  = !(((cyc - 2) % 800) >= 656 && ((cyc - 2) % 800) < 752);
                vs  = !((((cyc - 2) / 800) % 525) >= 490 && (((cyc - 2) / 800) % 525) < 492);
                col = m_pix(cyc - 2);
            end
            exp = {m_vis(cyc), m_addr(cyc), hs, vs, col, exp_bs, exp_ack};
        end
        check("outputs", act, exp);
        if (draw_ack) acks++;
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
        check("goto_cycle", 32'(cyc), 32'(t));
    endtask

    initial begin
        #16000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_low, hs_first, vs_low, vs_first;

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++)
                mem[b][i] = 12'($urandom);
        mem[0][0] = 12'hA5C;

        repeat (3) @(negedge clk);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_hsync", 32'(vga_hsync), 32'd1);
        check("rst_bsel", 32'(buffer_select), 32'd0);

        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("first_addr", 32'(read_addr), 32'd0);
        check("first_read_en", 32'(read_en), 32'd1);

        // Line 0: address steps, first pixel colour, hsync window.
        hs_low   = 0;
        hs_first = -1;
        for (int c = 0; c <= 801; c++) begin
            goto(c);
            if (!vga_hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (c == 3)   check("addr_h3", 32'(read_addr), 32'd0);
            if (c == 4)   check("addr_h4", 32'(read_addr), 32'd1);
            if (c == 7)   check("addr_h7", 32'(read_addr), 32'd1);
            if (c == 636) check("addr_h636", 32'(read_addr), 32'd159);
            if (c == 639) check("addr_h639", 32'(read_addr), 32'd159);
            if (c == 700) check("blank_black", 32'({vga_r, vga_g, vga_b}), 32'h000);
`ifdef SCANOUT_TEST_PATTERN_EN
            if (c == 2)   check("bar_h0", 32'({vga_r, vga_g, vga_b}), 32'hF00);
            if (c == 82)  check("bar_h80", 32'({vga_r, vga_g, vga_b}), 32'h0F0);
            if (c == 641) check("bar_h639", 32'({vga_r, vga_g, vga_b}), 32'h000);
`else
            if (c == 1)   check("pix0_early", 32'({vga_r, vga_g, vga_b}), 32'h000);
            if (c == 2)   check("pix0_colour", 32'({vga_r, vga_g, vga_b}), 32'hA5C);
`endif
        end
        check("hsync_low_count", 32'(hs_low), 32'd96);
        check("hsync_first_low", 32'(hs_first), 32'd658);

        goto(4 * 800);
        check("addr_v4", 32'(read_addr), 32'd160);

        goto(100 * 800 + int'($urandom_range(0, 799)));
        frame_done = 1'b1;

        goto(479 * 800 + 639);
        check("addr_last", 32'(read_addr), 32'd19199);
        check("no_early_ack", 32'(acks), 32'd0);

        goto(480 * 800);
        check("swap_pt_ack", 32'(draw_ack), 32'd0);
        check("swap_pt_bsel", 32'(buffer_select), 32'd0);
        goto(480 * 800 + 1);
        check("ack_pulse", 32'(draw_ack), 32'd1);
        check("bsel_toggled", 32'(buffer_select), 32'd1);
        frame_done = 1'b0;
        goto(480 * 800 + 2);
        check("ack_one_cycle", 32'(draw_ack), 32'd0);

        // Vertical sync window of the first frame (delayed 2 cycles).
        vs_low   = 0;
        vs_first = -1;
        for (int c = 480 * 800 + 2; c <= 525 * 800 + 1; c++) begin
            goto(c);
            if (!vga_vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = c;
            end
        end
        check("vsync_low_count", 32'(vs_low), 32'd1600);
        check("vsync_first_low", 32'(vs_first), 32'd392002);

        // Second frame, frame_done low: no swap.
        goto(420000 + 480 * 800 + 1);
        check("noswap_ack", 32'(draw_ack), 32'd0);
        check("noswap_bsel", 32'(buffer_select), 32'd1);
        check("ack_total_1", 32'(acks), 32'd1);

        // Reset mid-frame with frame_done pending.
        goto(840000 + 200 * 800 + 300);
        frame_done = 1'b1;
        #2 rstn = 1'b0;
        repeat (int'($urandom_range(2, 6))) @(negedge clk);
        check("midrst_bsel", 32'(buffer_select), 32'd0);
        check("midrst_read_en", 32'(read_en), 32'd0);
        check("midrst_sync", 32'({vga_hsync, vga_vsync}), 32'h3);
        check("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("rel_addr", 32'(read_addr), 32'd0);
        check("rel_bsel", 32'(buffer_select), 32'd0);

        goto(480 * 800 + 1);
        check("post_rst_ack", 32'(draw_ack), 32'd1);
        check("post_rst_bsel", 32'(buffer_select), 32'd1);
        frame_done = 1'b0;
        goto(480 * 800 + 3);
        check("ack_total_2", 32'(acks), 32'd2);

        summary_and_finish();
    end

endmodule
